// File: rtl/jtag_tap_ir_ctrl_if.sv
// rtl/jtag_tap_ir_ctrl_if.sv - JTAG serial pin bundle (tms/tdi in, tdo/tdo_en out)
interface jtag_tap_ir_ctrl_if;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;

    // master drives the pins (probe side), slave is the TAP
    modport master (output tms, output tdi, input tdo, input tdo_en);
    modport slave  (input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_tap_ir_ctrl.sv
// rtl/jtag_tap_ir_ctrl.sv - 1149.1 TAP FSM, IR, BYPASS and TDO mux; IDCODE register under JTAG_IDCODE_EN
module jtag_tap_ir_ctrl #(
    parameter int              IR_W       = 4,
    parameter logic [IR_W-1:0] BYPASS_OPC = {IR_W{1'b1}},
    parameter logic [IR_W-1:0] IDCODE_OPC = 1,
    parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001
) (
    input  logic                 tck,
    input  logic                 trst,
    jtag_tap_ir_ctrl_if.slave    jtag,
    input  logic                 dr_tdo,
    output logic [IR_W-1:0]      ir_out,
    output logic                 ext_dr_sel,
    output logic                 capture_dr,
    output logic                 shift_dr,
    output logic                 update_dr,
    output logic                 tlr,
    output logic                 rti
);

    localparam logic [3:0] S_TLR    = 4'h0;
    localparam logic [3:0] S_RTI    = 4'h1;
    localparam logic [3:0] S_SELDR  = 4'h2;
    localparam logic [3:0] S_CAPDR  = 4'h3;
    localparam logic [3:0] S_SHDR   = 4'h4;
    localparam logic [3:0] S_EX1DR  = 4'h5;
    localparam logic [3:0] S_PAUDR  = 4'h6;
    localparam logic [3:0] S_EX2DR  = 4'h7;
    localparam logic [3:0] S_UPDDR  = 4'h8;
    localparam logic [3:0] S_SELIR  = 4'h9;
    localparam logic [3:0] S_CAPIR  = 4'hA;
    localparam logic [3:0] S_SHIR   = 4'hB;
    localparam logic [3:0] S_EX1IR  = 4'hC;
    localparam logic [3:0] S_PAUIR  = 4'hD;
    localparam logic [3:0] S_EX2IR  = 4'hE;
    localparam logic [3:0] S_UPDIR  = 4'hF;

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = IDCODE_OPC;
`else
    localparam logic [IR_W-1:0] IR_RST = BYPASS_OPC;
`endif

    // Elaboration-time parameter sanity
    if (IR_W < 2) begin : g_bad_irw
        $error("IR_W must be at least 2");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("IDCODE_VAL bit 0 must be 1");
    end
    if (IDCODE_OPC == BYPASS_OPC) begin : g_bad_opc
        $error("IDCODE_OPC must differ from BYPASS_OPC");
    end

    logic [3:0]      state;
    logic [3:0]      nxt;
    logic [IR_W-1:0] ir_sr;
    logic            bypass;
    logic            dr_serial;

    // Standard 1149.1 TMS-driven next-state function
    always_comb begin
        nxt = state;
        case (state)
            S_TLR:   nxt = jtag.tms ? S_TLR   : S_RTI;
            S_RTI:   nxt = jtag.tms ? S_SELDR : S_RTI;
            S_SELDR: nxt = jtag.tms ? S_SELIR : S_CAPDR;
            S_CAPDR: nxt = jtag.tms ? S_EX1DR : S_SHDR;
            S_SHDR:  nxt = jtag.tms ? S_EX1DR : S_SHDR;
            S_EX1DR: nxt = jtag.tms ? S_UPDDR : S_PAUDR;
            S_PAUDR: nxt = jtag.tms ? S_EX2DR : S_PAUDR;
            S_EX2DR: nxt = jtag.tms ? S_UPDDR : S_SHDR;
            S_UPDDR: nxt = jtag.tms ? S_SELDR : S_RTI;
            S_SELIR: nxt = jtag.tms ? S_TLR   : S_CAPIR;
            S_CAPIR: nxt = jtag.tms ? S_EX1IR : S_SHIR;
            S_SHIR:  nxt = jtag.tms ? S_EX1IR : S_SHIR;
            S_EX1IR: nxt = jtag.tms ? S_UPDIR : S_PAUIR;
            S_PAUIR: nxt = jtag.tms ? S_EX2IR : S_PAUIR;
            S_EX2IR: nxt = jtag.tms ? S_UPDIR : S_SHIR;
            S_UPDIR: nxt = jtag.tms ? S_SELDR : S_RTI;
            default: nxt = S_TLR;
        endcase
    end

    // State register
    always_ff @(posedge tck or posedge trst) begin
        if (trst) state <= S_TLR;
        else      state <= nxt;
    end

    // Decodes registered from the next state so they are glitch-free for the whole state
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            tlr        <= 1'b1;
            rti        <= 1'b0;
            capture_dr <= 1'b0;
            shift_dr   <= 1'b0;
            update_dr  <= 1'b0;
        end else begin
            tlr        <= (nxt == S_TLR);
            rti        <= (nxt == S_RTI);
            capture_dr <= (nxt == S_CAPDR) && ext_dr_sel;
            shift_dr   <= (nxt == S_SHDR)  && ext_dr_sel;
            update_dr  <= (nxt == S_UPDDR) && ext_dr_sel;
        end
    end

    // IR shift register: capture 01 pattern, shift LSB out first
    always_ff @(posedge tck or posedge trst) begin
        if (trst)                  ir_sr <= '0;
        else if (state == S_CAPIR) ir_sr <= {{(IR_W-2){1'b0}}, 2'b01};
        else if (state == S_SHIR)  ir_sr <= {jtag.tdi, ir_sr[IR_W-1:1]};
    end

    // Active instruction: committed on the falling edge in Update-IR, reloaded in TLR
    always_ff @(negedge tck or posedge trst) begin
        if (trst)                  ir_out <= IR_RST;
        else if (state == S_UPDIR) ir_out <= ir_sr;
        else if (state == S_TLR)   ir_out <= IR_RST;
    end

    // Single-bit bypass register
    always_ff @(posedge tck or posedge trst) begin
        if (trst)                  bypass <= 1'b0;
        else if (state == S_CAPDR) bypass <= 1'b0;
        else if (state == S_SHDR)  bypass <= jtag.tdi;
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_sr;

    // IDCODE register, loaded only when IDCODE is the active instruction
    always_ff @(posedge tck or posedge trst) begin
        if (trst) idcode_sr <= '0;
        else if (ir_out == IDCODE_OPC) begin
            if (state == S_CAPDR)     idcode_sr <= IDCODE_VAL;
            else if (state == S_SHDR) idcode_sr <= {jtag.tdi, idcode_sr[31:1]};
        end
    end

    assign ext_dr_sel = (ir_out != BYPASS_OPC) && (ir_out != IDCODE_OPC);
    assign dr_serial  = ext_dr_sel ? dr_tdo :
                        (ir_out == IDCODE_OPC) ? idcode_sr[0] : bypass;
`else
    assign ext_dr_sel = (ir_out != BYPASS_OPC);
    assign dr_serial  = ext_dr_sel ? dr_tdo : bypass;
`endif

    // TDO launched on the falling edge; holds its value outside shift states
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            jtag.tdo    <= 1'b0;
            jtag.tdo_en <= 1'b0;
        end else if (state == S_SHIR) begin
            jtag.tdo    <= ir_sr[0];
            jtag.tdo_en <= 1'b1;
        end else if (state == S_SHDR) begin
            jtag.tdo    <= dr_serial;
            jtag.tdo_en <= 1'b1;
        end else begin
            jtag.tdo_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ir_ctrl.sv
// tb/tb_jtag_tap_ir_ctrl.sv - directed-vector bench for jtag_tap_ir_ctrl
module tb_jtag_tap_ir_ctrl;
    localparam int IR_W = 4;
`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] RST_IR = 4'h1;
`else
    localparam logic [3:0] RST_IR = 4'hF;
`endif

    logic            tck = 1'b0;
    logic            trst = 1'b1;
    logic            dr_tdo = 1'b0;
    logic [IR_W-1:0] ir_out;
    logic            ext_dr_sel, capture_dr, shift_dr, update_dr, tlr, rti;

    int n_vec = 0;
    int n_bad = 0;

    jtag_tap_ir_ctrl_if jif ();

    jtag_tap_ir_ctrl #(.IR_W(IR_W)) dut (
        .tck        (tck),
        .trst       (trst),
        .jtag       (jif),
        .dr_tdo     (dr_tdo),
        .ir_out     (ir_out),
        .ext_dr_sel (ext_dr_sel),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .tlr        (tlr),
        .rti        (rti)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One tck period: drive pins, pass the rising and falling edge, sample after the fall
    task automatic cyc(input logic m, input logic d);
        jif.tms = m;
        jif.tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // From RTI: load an instruction, return the captured bits seen on tdo, end in RTI
    task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cap[0] = jif.tdo;
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, v[i]);
            if (i < 3) cap[i+1] = jif.tdo;
        end
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    logic [3:0]  cap;
    logic [3:0]  s;
    logic [31:0] id;

    initial begin
        jif.tms = 1'b1;
        jif.tdi = 1'b0;
        #12;
        chk("rst_tlr", tlr, 1);
        chk("rst_ir", ir_out, RST_IR);
        chk("rst_tdo_en", jif.tdo_en, 0);
        chk("rst_tdo", jif.tdo, 0);
        trst = 1'b0;

        repeat (5) cyc(1'b1, 1'b0);
        chk("tms5_tlr", tlr, 1);
        chk("tms5_ir", ir_out, RST_IR);
        chk("tms5_tdo_en", jif.tdo_en, 0);
        cyc(1'b0, 1'b0);
        chk("rti", rti, 1);

        load_ir(4'h2, cap);
        chk("ir_capture", cap, 4'h1);
        chk("ir_load2", ir_out, 4'h2);
        chk("ext_sel2", ext_dr_sel, 1);

        load_ir(4'hF, cap);
        chk("ir_loadF", ir_out, 4'hF);
        chk("ext_selF", ext_dr_sel, 0);

        // Bypass: tdi 1,0,1,1 -> tdo 0,1,0,1
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        s[0] = jif.tdo;
        chk("byp_shift_dr", shift_dr, 0);
        chk("byp_tdo_en", jif.tdo_en, 1);
        cyc(1'b0, 1'b1); s[1] = jif.tdo;
        cyc(1'b0, 1'b0); s[2] = jif.tdo;
        cyc(1'b0, 1'b1); s[3] = jif.tdo;
        cyc(1'b1, 1'b1);
        chk("byp_stream", s, 4'hA);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);

`ifdef JTAG_IDCODE_EN
        repeat (5) cyc(1'b1, 1'b0);
        chk("tlr_ir_idcode", ir_out, 4'h1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("id_capture_dr", capture_dr, 0);
        cyc(1'b0, 1'b0);
        id[0] = jif.tdo;
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 1'b0);
            id[i] = jif.tdo;
        end
        chk("idcode", id, 32'h1000_0001);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
`endif

        // External DR walk through Pause
        load_ir(4'h2, cap);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("ext_capture", capture_dr, 1);
        chk("ext_cap_shift", shift_dr, 0);
        dr_tdo = 1'b1;
        cyc(1'b0, 1'b0);
        chk("ext_shift", shift_dr, 1);
        chk("ext_tdo1", jif.tdo, 1);
        chk("ext_tdo_en", jif.tdo_en, 1);
        dr_tdo = 1'b0;
        cyc(1'b1, 1'b0);
        chk("ext_ex1_shift", shift_dr, 0);
        chk("ext_ex1_tdo", jif.tdo, 1);
        chk("ext_ex1_tdo_en", jif.tdo_en, 0);
        cyc(1'b0, 1'b0);
        chk("ext_pause_tdo", jif.tdo, 1);
        chk("ext_pause_ir", ir_out, 4'h2);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("ext_tdo0", jif.tdo, 0);
        chk("ext_shift2", shift_dr, 1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("ext_update", update_dr, 1);
        cyc(1'b0, 1'b0);
        chk("ext_update_end", update_dr, 0);
        chk("ext_rti", rti, 1);

        // Asynchronous trst in the middle of Shift-IR
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("mid_tdo_en", jif.tdo_en, 1);
        #1 trst = 1'b1;
        #1;
        chk("trst_tlr", tlr, 1);
        chk("trst_ir", ir_out, RST_IR);
        chk("trst_tdo_en", jif.tdo_en, 0);
        chk("trst_ext_sel", ext_dr_sel, 0);
        #2 trst = 1'b0;
        cyc(1'b1, 1'b0);
        chk("post_trst_tlr", tlr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
